// File: rtl/mvau_wmem_pkg.sv
// Shared types and helpers for the MVAU runtime weight loader.
package mvau_wmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } wmem_load_state_t;

    // Number of stream beats that make up one complete weight load.
    function automatic int unsigned total_beats(input int unsigned pe, input int unsigned depth);
        return pe * depth;
    endfunction

    // Index width that stays at least one bit for single-entry ranges.
    function automatic int unsigned idx_bw(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mvau_wmem_addr_gen.sv
// Address-major / PE-minor beat counters for the weight loader.
module mvau_wmem_addr_gen
    import mvau_wmem_pkg::*;
#(
    parameter int unsigned PE           = 2,
    parameter int unsigned WMEM_DEPTH   = 4,
    parameter int unsigned WMEM_ADDR_BW = 4,
    parameter int unsigned PE_BW        = idx_bw(PE)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    advance_i,
    output logic [PE_BW-1:0]        pe_idx_o,
    output logic [WMEM_ADDR_BW-1:0] addr_o,
    output logic                    last_o
);

    localparam logic [PE_BW-1:0]        PE_LAST   = PE_BW'(PE - 1);
    localparam logic [WMEM_ADDR_BW-1:0] ADDR_LAST = WMEM_ADDR_BW'(WMEM_DEPTH - 1);

    logic [PE_BW-1:0]        pe_q, pe_d;
    logic [WMEM_ADDR_BW-1:0] addr_q, addr_d;

    always_comb begin
        pe_d   = pe_q;
        addr_d = addr_q;
        if (clear_i) begin
            pe_d   = '0;
            addr_d = '0;
        end else if (advance_i) begin
            if (pe_q == PE_LAST) begin
                pe_d   = '0;
                addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + WMEM_ADDR_BW'(1);
            end else begin
                pe_d = pe_q + PE_BW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pe_q   <= '0;
            addr_q <= '0;
        end else begin
            pe_q   <= pe_d;
            addr_q <= addr_d;
        end
    end

    assign pe_idx_o = pe_q;
    assign addr_o   = addr_q;
    assign last_o   = (pe_q == PE_LAST) && (addr_q == ADDR_LAST);

endmodule

// File: rtl/mvau_wmem_loader.sv
// Streams weight words from AXI-Stream into the per-PE weight memory write ports.
// Handshake: a beat transfers on any rising edge where s_axis_tvalid and s_axis_tready are both high.
module mvau_wmem_loader
    import mvau_wmem_pkg::*;
#(
    parameter int unsigned PE           = 2,
    parameter int unsigned SIMD         = 2,
    parameter int unsigned TW           = 1,
    parameter int unsigned WMEM_DEPTH   = 4,
    parameter int unsigned WMEM_ADDR_BW = 4
) (
    input  logic                    aclk,
    input  logic                    rst,
    input  logic                    load_start,
    output logic                    load_busy,
    output logic                    load_done,
    output logic                    load_err,
    input  logic [SIMD*TW-1:0]      s_axis_tdata,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic [PE-1:0]           wmem_wr_en,
    output logic [WMEM_ADDR_BW-1:0] wmem_wr_addr,
    output logic [SIMD*TW-1:0]      wmem_wr_data,
    output wmem_load_state_t        dbg_state_o
);

    localparam int unsigned DW    = SIMD * TW;
    localparam int unsigned PE_BW = idx_bw(PE);

    wmem_load_state_t state_q, state_d;

    logic [PE_BW-1:0]        pe_idx;
    logic [WMEM_ADDR_BW-1:0] cur_addr;
    logic                    cur_last;
    logic                    beat;
    logic                    start_acc;
    logic [PE-1:0]           onehot;

    logic [PE-1:0]           wr_en_q;
    logic [WMEM_ADDR_BW-1:0] wr_addr_q;
    logic [DW-1:0]           wr_data_q;
    logic                    err_q;

    assign beat      = (state_q == LOAD) && s_axis_tvalid;
    assign start_acc = (state_q == IDLE) && load_start;

    mvau_wmem_addr_gen #(
        .PE           (PE),
        .WMEM_DEPTH   (WMEM_DEPTH),
        .WMEM_ADDR_BW (WMEM_ADDR_BW),
        .PE_BW        (PE_BW)
    ) u_addr_gen (
        .clk_i     (aclk),
        .rst_i     (rst),
        .clear_i   (start_acc),
        .advance_i (beat),
        .pe_idx_o  (pe_idx),
        .addr_o    (cur_addr),
        .last_o    (cur_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load_start) state_d = LOAD;
            LOAD:    if (beat && cur_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        onehot = '0;
        for (int p = 0; p < int'(PE); p++) begin
            onehot[p] = (pe_idx == PE_BW'(p));
        end
    end

    // Address and data hold their last value between writes; only wr_en marks a valid write.
    always_ff @(posedge aclk) begin
        if (rst) begin
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            wr_en_q <= beat ? onehot : '0;
            if (beat) begin
                wr_addr_q <= cur_addr;
                wr_data_q <= s_axis_tdata;
            end
            if (start_acc) begin
                err_q <= 1'b0;
            end else if (beat && (s_axis_tlast != cur_last)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign s_axis_tready = (state_q == LOAD);
    assign load_busy     = (state_q != IDLE);
    assign load_done     = (state_q == DONE);
    assign load_err      = err_q;
    assign wmem_wr_en    = wr_en_q;
    assign wmem_wr_addr  = wr_addr_q;
    assign wmem_wr_data  = wr_data_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mvau_wmem_loader.sv
// Directed-sequence bench with randomized weight data for mvau_wmem_loader.
module tb_mvau_wmem_loader;
    import mvau_wmem_pkg::*;

    localparam int PE    = 2;
    localparam int SIMD  = 2;
    localparam int TW    = 1;
    localparam int DEPTH = 4;
    localparam int ABW   = 4;
    localparam int DW    = SIMD * TW;
    localparam int BEATS = int'(total_beats(PE, DEPTH));
    localparam int EW    = 16 + PE + ABW + DW;

    logic            aclk;
    logic            rst;
    logic            load_start;
    logic            load_busy, load_done, load_err;
    logic [DW-1:0]   s_tdata;
    logic            s_tvalid, s_tlast, s_axis_tready;
    logic [PE-1:0]   wmem_wr_en;
    logic [ABW-1:0]  wmem_wr_addr;
    logic [DW-1:0]   wmem_wr_data;
    wmem_load_state_t dbg_state;

    logic            load_start1;
    logic            busy1, done1, err1;
    logic [DW-1:0]   tdata1;
    logic            tvalid1, tlast1, tready1;
    logic [0:0]      wr_en1;
    logic [0:0]      wr_addr1;
    logic [DW-1:0]   wr_data1;
    wmem_load_state_t dbg_state1;

    mvau_wmem_loader #(
        .PE(PE), .SIMD(SIMD), .TW(TW), .WMEM_DEPTH(DEPTH), .WMEM_ADDR_BW(ABW)
    ) dut (
        .aclk(aclk), .rst(rst), .load_start(load_start),
        .load_busy(load_busy), .load_done(load_done), .load_err(load_err),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(s_axis_tready),
        .wmem_wr_en(wmem_wr_en), .wmem_wr_addr(wmem_wr_addr), .wmem_wr_data(wmem_wr_data),
        .dbg_state_o(dbg_state)
    );

    mvau_wmem_loader #(
        .PE(1), .SIMD(SIMD), .TW(TW), .WMEM_DEPTH(1), .WMEM_ADDR_BW(1)
    ) dut1 (
        .aclk(aclk), .rst(rst), .load_start(load_start1),
        .load_busy(busy1), .load_done(done1), .load_err(err1),
        .s_axis_tdata(tdata1), .s_axis_tvalid(tvalid1), .s_axis_tlast(tlast1),
        .s_axis_tready(tready1),
        .wmem_wr_en(wr_en1), .wmem_wr_addr(wr_addr1), .wmem_wr_data(wr_data1),
        .dbg_state_o(dbg_state1)
    );

    // clock / cycle counter
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: expected writes {cycle, wr_en, addr, data}
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;
    logic [DW-1:0] cap_mem   [PE][DEPTH];
    logic [DW-1:0] model_mem [PE][DEPTH];
    int wr_cnt   = 0;
    int done_cnt = 0;
    int done_cyc = 0;

    always @(negedge aclk) begin
        if (load_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (wmem_wr_en != '0) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check("spurious_wr", 32'(wmem_wr_en), 32'h0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_cycle", 32'(16'(cyc)), 32'(mon_e[EW-1:EW-16]));
                check("wr_en",    32'(wmem_wr_en), 32'(mon_e[DW+ABW+PE-1:DW+ABW]));
                check("wr_addr",  32'(wmem_wr_addr), 32'(mon_e[DW+ABW-1:DW]));
                check("wr_data",  32'(wmem_wr_data), 32'(mon_e[DW-1:0]));
            end
            for (int p = 0; p < PE; p++) begin
                if (wmem_wr_en[p] && int'(wmem_wr_addr) < DEPTH) cap_mem[p][int'(wmem_wr_addr)] = wmem_wr_data;
            end
        end
    end

    // driver tasks
    int k;
    int start_cyc;
    logic model_err;
    logic [DW-1:0] data_v [BEATS];

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_start();
        load_start = 1'b1;
        start_cyc  = cyc;
        tick();
        load_start = 1'b0;
        k = 0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic last, input int gap);
        logic acc;
        bit   ok;
        int   p, a;
        repeat (gap) tick();
        s_tdata  = d;
        s_tlast  = last;
        s_tvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            acc = s_axis_tready;
            tick();
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        check("beat_accepted", 32'(ok), 32'h1);
        if (ok) begin
            p = k % PE;
            a = k / PE;
            model_mem[p][a] = d;
            exp_q.push_back({16'(cyc), PE'(1 << p), ABW'(a), d});
            k++;
        end
    endtask

    task automatic run_load(input int gap, input int la, input bit poke, input int exp_delay);
        int   done0, wr0;
        logic tl;
        done0 = done_cnt;
        wr0   = wr_cnt;
        for (int p = 0; p < PE; p++)
            for (int a = 0; a < DEPTH; a++) cap_mem[p][a] = 'x;
        do_start();
        model_err = 1'b0;
        check("busy_after_start", 32'(load_busy), 32'h1);
        check("tready_in_load", 32'(s_axis_tready), 32'h1);
        check("err_cleared_on_start", 32'(load_err), 32'h0);
        for (int j = 0; j < BEATS; j++) begin
            tl = (j == la);
            if (poke && j == 3) load_start = 1'b1;
            send_beat(data_v[j], tl, gap);
            load_start = 1'b0;
            model_err = model_err | (tl != (j == BEATS - 1));
            check("err_track", 32'(load_err), 32'(model_err));
            check("busy_during_load", 32'(load_busy), 32'h1);
        end
        check("state_done", 32'(dbg_state), 32'(DONE));
        if (poke) load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("idle_after_done", 32'(dbg_state), 32'(IDLE));
        check("busy_low_after_done", 32'(load_busy), 32'h0);
        check("tready_low_after_done", 32'(s_axis_tready), 32'h0);
        repeat (3) tick();
        check("done_pulses", 32'(done_cnt - done0), 32'h1);
        check("done_delay", 32'(done_cyc - start_cyc), 32'(exp_delay));
        check("write_count", 32'(wr_cnt - wr0), 32'(BEATS));
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        check("err_final", 32'(load_err), 32'(model_err));
        for (int p = 0; p < PE; p++)
            for (int a = 0; a < DEPTH; a++)
                check($sformatf("mem_p%0d_a%0d", p, a), 32'(cap_mem[p][a]), 32'(model_mem[p][a]));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  32'(load_busy), 32'h0);
        check({tag, "_done"},  32'(load_done), 32'h0);
        check({tag, "_err"},   32'(load_err), 32'h0);
        check({tag, "_tready"}, 32'(s_axis_tready), 32'h0);
        check({tag, "_wr_en"}, 32'(wmem_wr_en), 32'h0);
        check({tag, "_wr_addr"}, 32'(wmem_wr_addr), 32'h0);
        check({tag, "_wr_data"}, 32'(wmem_wr_data), 32'h0);
        check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    endtask

    task automatic randomize_data();
        for (int j = 0; j < BEATS; j++) data_v[j] = DW'($urandom_range(0, (1 << DW) - 1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        load_start = 1'b0;
        s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
        load_start1 = 1'b0;
        tdata1 = '0; tvalid1 = 1'b0; tlast1 = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // contiguous load with the 0..3,0..3 pattern
        for (int j = 0; j < BEATS; j++) data_v[j] = DW'(j % 4);
        run_load(0, BEATS - 1, 1'b0, 9);
        check("pattern_m0_a1", 32'(cap_mem[0][1]), 32'h2);
        check("pattern_m1_a2", 32'(cap_mem[1][2]), 32'h1);

        // random contiguous load
        randomize_data();
        run_load(0, BEATS - 1, 1'b0, 9);

        // tvalid toggled every other cycle
        randomize_data();
        run_load(1, BEATS - 1, 1'b0, 17);

        // misplaced tlast: on beat 3, missing on beat 8
        randomize_data();
        run_load(0, 2, 1'b0, 9);

        // next start clears load_err
        randomize_data();
        run_load(0, BEATS - 1, 1'b0, 9);

        // load_start pulsed in LOAD and in DONE
        randomize_data();
        run_load(0, BEATS - 1, 1'b1, 9);

        // reset in the middle of a load
        randomize_data();
        do_start();
        for (int j = 0; j < 5; j++) send_beat(data_v[j], 1'b0, 0);
        rst = 1'b1;
        tick();
        check_all_zero("midload_reset");
        rst = 1'b0;
        tick();
        randomize_data();
        run_load(0, BEATS - 1, 1'b0, 9);

        // single-PE, single-word instance
        data_v[0] = DW'($urandom_range(0, (1 << DW) - 1));
        load_start1 = 1'b1;
        tick();
        load_start1 = 1'b0;
        check("pe1_busy", 32'(busy1), 32'h1);
        check("pe1_tready", 32'(tready1), 32'h1);
        tdata1 = data_v[0]; tvalid1 = 1'b1; tlast1 = 1'b1;
        tick();
        tvalid1 = 1'b0; tlast1 = 1'b0;
        check("pe1_wr_en", 32'(wr_en1), 32'h1);
        check("pe1_wr_addr", 32'(wr_addr1), 32'h0);
        check("pe1_wr_data", 32'(wr_data1), 32'(data_v[0]));
        check("pe1_done", 32'(done1), 32'h1);
        check("pe1_err", 32'(err1), 32'h0);
        tick();
        check("pe1_wr_en_after", 32'(wr_en1), 32'h0);
        check("pe1_done_after", 32'(done1), 32'h0);
        check("pe1_busy_after", 32'(busy1), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
